// File: rtl/ula_io_if.sv
// CPU bus bundle between the Z80 core and the ULA I/O block.
// Strobes are active-low; q/irq flow back to the CPU.
interface ula_io_if;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        m1;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        irq;

  modport master (
    output iorq, rd, wr, m1, a, d,
    input  q, irq
  );

  modport slave (
    input  iorq, rd, wr, m1, a, d,
    output q, irq
  );
endinterface

// File: rtl/ula_io.sv
// ULA I/O: port FE (border/speaker/mic/keys/ear), frame counter, irq.
// Define ULA_KEMPSTON_EN to add the Kempston joystick on port 1F.
module ula_io (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  ula_io_if.slave     bus,
  input  logic [39:0] keys,
  input  logic        ear,
`ifdef ULA_KEMPSTON_EN
  input  logic [4:0]  joy,
`endif
  output logic [2:0]  border,
  output logic        speaker,
  output logic        mic
);

  localparam logic [16:0] FRAME_LAST = 17'd69887;
  localparam logic [16:0] IRQ_LEN    = 17'd32;

  logic [16:0] cnt_q, cnt_d;
  logic        mask_q, mask_d;
  logic        irq_q, irq_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  border_q;
  logic        spk_q, mic_q;
  logic        wrh_q;

  logic        io, ack, fe;
  logic        wr_fe, rd_fe;
  logic        wrap, latch;
  logic [4:0]  k;

  assign io    = !bus.iorq & bus.m1;
  assign ack   = !bus.iorq & !bus.m1;
  assign fe    = io & !bus.a[0];
  assign wr_fe = fe & !bus.wr;
  assign rd_fe = fe & !bus.rd;
  assign latch = wr_fe & !wrh_q;
  assign wrap  = ce & (cnt_q == FRAME_LAST);

`ifndef ULA_KEMPSTON_EN
  logic unused_bits;
  assign unused_bits = ^{bus.a[7:1], bus.d[7:5]};
`else
  logic unused_bits;
  assign unused_bits = ^bus.d[7:5];
`endif

  always_comb begin
    k = '1;
    for (int r = 0; r < 8; r++) begin
      if (!bus.a[8+r]) k = k & keys[5*r +: 5];
    end
  end

  always_comb begin
    q_d = 8'hFF;
    if (rd_fe) begin
      q_d = {1'b1, ear, 1'b1, k};
    end
`ifdef ULA_KEMPSTON_EN
    else if (io & !bus.rd & (bus.a[7:0] == 8'h1F)) begin
      q_d = {3'b000, joy};
    end
`endif
  end

  // Ack masks irq until the next wrap; ack wins a same-clock wrap.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (ce) cnt_d = wrap ? 17'd0 : cnt_q + 17'd1;
    if (wrap) mask_d = 1'b0;
    if (ack) mask_d = 1'b1;
    irq_d = !((cnt_d < IRQ_LEN) & !mask_d);
  end

  // Edge history resets high so a write held across reset never latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      mask_q   <= 1'b1;
      irq_q    <= 1'b1;
      q_q      <= 8'hFF;
      border_q <= '0;
      spk_q    <= 1'b0;
      mic_q    <= 1'b0;
      wrh_q    <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
      q_q    <= q_d;
      wrh_q  <= wr_fe;
      if (latch) begin
        border_q <= bus.d[2:0];
        mic_q    <= bus.d[3];
        spk_q    <= bus.d[4];
      end
    end
  end

  assign bus.q   = q_q;
  assign bus.irq = irq_q;
  assign border  = border_q;
  assign speaker = spk_q;
  assign mic     = mic_q;

endmodule
